// File: rtl/modular_inverse.sv
// Purpose : d = value_in^-1 mod modulus_in via iterative extended Euclid with a
//           bit-serial restoring divider (one quotient bit per cycle).
// Latency : 2 + k*(WIDTH+2) + 2 cycles, counted inclusively from the accept cycle
//           to the valid_out cycle; k = Euclid iterations. m < 2 reports in 2 cycles.
// Backpressure: a single request is in flight at a time. ready_in is sampled only
//           in IDLE. Strobes while busy are dropped, not queued.
// Ports   : clk_in, rst_in (async, active-high) | ready_in, value_in (a), modulus_in (m)
//           | value_out (d, 0 when error), busy_out, valid_out (1-cycle pulse),
//           error_out (no inverse: gcd(a,m) != 1 or m < 2)
module modular_inverse #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             busy_out,
  output logic             valid_out,
  output logic             error_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIVIDE, S_UPDATE, S_FINISH, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]        m_reg, r0, r1, q, rem;
  logic signed [WIDTH+1:0] t0, t1, t_new;
  logic [CW-1:0]           cnt;
  logic [WIDTH:0]          trial;
  logic                    fits;
  logic [WIDTH-1:0]        rem_sub;
  logic                    small_m;

  assign small_m = (modulus_in < WIDTH'(2));

  // Restoring division step: the shift register q starts as the dividend and
  // fills up with quotient bits as the dividend bits shift out of its top.
  assign trial   = {rem, q[WIDTH-1]};
  assign fits    = (trial >= {1'b0, r1});
  // The true difference is < r1 whenever it is used, so WIDTH bits suffice.
  assign rem_sub = trial[WIDTH-1:0] - r1;

  // Bezout coefficient update. Only the low WIDTH+2 bits of the full product are
  // kept; they match the full-width result truncated, and |t| <= m keeps them exact.
  assign t_new = t0 - ($signed({2'b00, q}) * t1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    valid_out = 1'b0;
    case (state)
      S_IDLE:   if (ready_in) state_nxt = small_m ? S_DONE : S_CHECK;
      S_CHECK:  begin
        busy_out  = 1'b1;
        state_nxt = (r1 == '0) ? S_FINISH : S_DIVIDE;
      end
      S_DIVIDE: begin
        busy_out = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        busy_out  = 1'b1;
        state_nxt = S_CHECK;
      end
      S_FINISH: begin
        busy_out  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:   begin
        valid_out = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_reg     <= '0;
      r0        <= '0;
      r1        <= '0;
      q         <= '0;
      rem       <= '0;
      t0        <= '0;
      t1        <= '0;
      cnt       <= '0;
      value_out <= '0;
      error_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ready_in) begin
          m_reg <= modulus_in;
          r0    <= modulus_in;
          r1    <= value_in;
          t0    <= '0;
          t1    <= (WIDTH+2)'(1);
          // Degenerate modulus: result is published straight away with DONE.
          if (small_m) begin
            error_out <= 1'b1;
            value_out <= '0;
          end
        end
        S_CHECK: if (r1 != '0) begin
          q   <= r0;
          rem <= '0;
          cnt <= '0;
        end
        S_DIVIDE: begin
          q   <= {q[WIDTH-2:0], fits};
          rem <= fits ? rem_sub : trial[WIDTH-1:0];
          cnt <= cnt + CW'(1);
        end
        S_UPDATE: begin
          r0 <= r1;
          r1 <= rem;
          t0 <= t1;
          t1 <= t_new;
        end
        S_FINISH: begin
          if (r0 != WIDTH'(1)) begin
            error_out <= 1'b1;
            value_out <= '0;
          end else begin
            error_out <= 1'b0;
            // Negative coefficient folds into [0, m) with one add of m.
            value_out <= t0[WIDTH+1] ? (t0[WIDTH-1:0] + m_reg) : t0[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_inverse.sv
// Purpose : self-checking bench for modular_inverse (WIDTH=16): directed vectors,
//           busy-ignore, back-to-back, async reset abort and a random sweep.
// Ports   : drives clk_in, rst_in, ready_in, value_in, modulus_in; observes all outputs.
module tb_modular_inverse;

  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         ready_in = 1'b0;
  logic [W-1:0] value_in = '0;
  logic [W-1:0] modulus_in = '0;
  logic [W-1:0] value_out;
  logic         busy_out;
  logic         valid_out;
  logic         error_out;

  modular_inverse #(.WIDTH(W)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .ready_in  (ready_in),
    .value_in  (value_in),
    .modulus_in(modulus_in),
    .value_out (value_out),
    .busy_out  (busy_out),
    .valid_out (valid_out),
    .error_out (error_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    longint a;
    longint m;
    longint val;
    bit     err;
    int     k;
    int     c;
  } exp_t;

  exp_t pend[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: textbook extended Euclid on plain integers; k counts quotient steps.
  task automatic model(input longint a, input longint m,
                       output longint val, output bit err, output int k);
    longint r0, r1, s0, s1, qq, tmp;
    val = 0; err = 1'b1; k = 0;
    if (m < 2) return;
    r0 = m; r1 = a; s0 = 0; s1 = 1;
    while (r1 != 0) begin
      qq  = r0 / r1;
      tmp = r0 % r1;  r0 = r1; r1 = tmp;
      tmp = s0 - qq * s1; s0 = s1; s1 = tmp;
      k++;
    end
    if (r0 == 1) begin
      err = 1'b0;
      val = (s0 < 0) ? s0 + m : s0;
    end
  endtask

  // Compare process: every cycle with a request in flight or a valid pulse.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out) begin
        if (pend.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          int   lat;
          e   = pend.pop_front();
          lat = cyc - e.c + 1;
          check("value", value_out, e.val);
          check("error", error_out, e.err);
          check("busy_on_valid", busy_out, 0);
          if (e.m < 2) check("latency_small_m", lat <= 3, 1);
          else         check("latency", lat, e.k * (W + 2) + 4);
          if (!e.err) check("a_times_d_mod_m", (e.a * value_out) % e.m, 1);
        end
      end else if (pend.size() != 0 && cyc > pend[0].c && pend[0].m >= 2) begin
        check("busy_high", busy_out, 1);
      end
    end
  end

  // Present one request; call on a negedge while the DUT is idle.
  task automatic request(input longint a, input longint m);
    longint v; bit e; int k;
    model(a, m, v, e, k);
    value_in   = W'(a);
    modulus_in = W'(m);
    ready_in   = 1'b1;
    pend.push_back('{a, m, v, e, k, cyc});
    @(negedge clk_in);
    ready_in = 1'b0;
  endtask

  // Wait for the valid pulse, then one more cycle to land in the idle cycle.
  task automatic wait_done();
    int n = 0;
    while (!valid_out && n < 700) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 700) begin
      total++; bad++;
      $display("FAIL timeout: no valid_out after %0d cycles, wanted one", n);
      pend.delete();
    end
    @(negedge clk_in);
  endtask

  task automatic run(input longint a, input longint m);
    request(a, m);
    wait_done();
  endtask

  // Pin the model to hand-computed answers, then run the vector on the DUT.
  task automatic directed(input longint a, input longint m, input longint lit_val, input bit lit_err);
    longint v; bit e; int k;
    model(a, m, v, e, k);
    check("model_pin_val", v, lit_val);
    check("model_pin_err", e, lit_err);
    run(a, m);
  endtask

  initial begin
    #1 rst_in = 1'b1;
    #1;
    check("reset_value", value_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_error", error_out, 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    directed(17, 3120, 2753, 0);
    directed(3, 7, 5, 0);
    directed(10, 7, 5, 0);
    directed(1, 2, 1, 0);
    directed(6, 9, 0, 1);
    directed(0, 11, 0, 1);
    directed(7, 7, 0, 1);
    directed(5, 1, 0, 1);
    directed(5, 0, 0, 1);
    directed(65535, 65534, 1, 0);

    // Strobes while busy must be dropped; then a back-to-back request.
    request(17, 3120);
    for (int i = 0; i < 5; i++) begin
      value_in   = W'(3 + i);
      modulus_in = W'(7 + 2 * i);
      ready_in   = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      repeat (3) @(negedge clk_in);
    end
    wait_done();
    run(3, 7);

    // Async reset mid-division: outputs clear at once, no pulse follows.
    request(17, 3120);
    repeat (5) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("abort_value", value_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_valid", valid_out, 0);
    check("abort_error", error_out, 0);
    pend.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    directed(3, 7, 5, 0);

    for (int i = 0; i < 250; i++) begin
      longint a, m;
      a = longint'($urandom_range(0, 65535));
      m = (i % 4 == 0) ? longint'($urandom_range(2, 50)) : longint'($urandom_range(2, 65535));
      run(a, m);
    end

    check("nothing_outstanding", pend.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
